// File: rtl/cpu_pkg.sv
// Shared CPU pipeline definitions: hazard FSM encoding, register constants and
// default limits for the data-memory watchdog.
package cpu_pkg;

  typedef enum logic [1:0] {
    HZ_RUN   = 2'd0,
    HZ_MWAIT = 2'd1,
    HZ_DONE  = 2'd2
  } hz_state_e;

  localparam logic [4:0]  REG_ZERO         = 5'd0;
  localparam int unsigned MAX_WAIT_DEFAULT = 15;
  localparam int unsigned CNT_W_DEFAULT    = 4;

endpackage

// File: rtl/hazard_ctrl_wdog.sv
// Wait counter for an outstanding data-memory access, with saturation and a
// sticky error flag raised when the access exceeds MAX_WAIT cycles.
module hazard_ctrl_wdog import cpu_pkg::*; #(
  parameter int unsigned MAX_WAIT = MAX_WAIT_DEFAULT,
  parameter int unsigned CNT_W    = CNT_W_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic i_active,
  input  logic i_ack,
  output logic o_wd_err
);

  logic [CNT_W-1:0] r_cnt;
  logic             r_wd_err;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_sat;
  logic             w_counting;

  assign w_sat      = (r_cnt == CNT_W'(MAX_WAIT));
  assign w_counting = i_active & ~i_ack;
  assign w_cnt_nxt  = w_sat ? r_cnt : r_cnt + CNT_W'(1);

  // Count only while still waiting; any exit from the wait clears the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_wd_err <= 1'b0;
    end else begin
      r_cnt <= w_counting ? w_cnt_nxt : '0;
      if (w_counting && (w_cnt_nxt == CNT_W'(MAX_WAIT))) begin
        r_wd_err <= 1'b1;
      end
    end
  end

  assign o_wd_err = r_wd_err;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, taken-branch flush and pipeline
// freeze during multi-cycle data-memory accesses.
module hazard_ctrl import cpu_pkg::*; #(
  parameter int unsigned MAX_WAIT = MAX_WAIT_DEFAULT,
  parameter int unsigned CNT_W    = CNT_W_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] if_id_rs1,
  input  logic [4:0] if_id_rs2,
  input  logic       id_ex_memread,
  input  logic [4:0] id_ex_rd,
  input  logic       ex_branch_taken,
  input  logic       ex_mem_memaccess,
  input  logic       dmem_ack,
  output logic       dmem_req,
  output logic       pc_write,
  output logic       if_id_write,
  output logic       if_id_flush,
  output logic       id_ex_bubble,
  output logic       ex_mem_hold,
  output logic       mem_wb_bubble,
  output logic       wd_err
);

  hz_state_e r_state;
  hz_state_e w_state_nxt;
  logic      w_load_use;
  logic      w_in_mwait;

  assign w_load_use = id_ex_memread & (id_ex_rd != REG_ZERO) &
                      ((id_ex_rd == if_id_rs1) | (id_ex_rd == if_id_rs2));
  assign w_in_mwait = (r_state == HZ_MWAIT);

  always_ff @(posedge clk) begin
    if (rst) r_state <= HZ_RUN;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      HZ_RUN:   if (ex_mem_memaccess) w_state_nxt = HZ_MWAIT;
      HZ_MWAIT: if (dmem_ack) w_state_nxt = HZ_DONE;
      HZ_DONE:  w_state_nxt = HZ_RUN;
      default:  w_state_nxt = HZ_RUN;
    endcase
  end

  // DONE reuses the RUN priority but never starts a new access itself.
  always_comb begin
    dmem_req      = 1'b0;
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_bubble  = 1'b0;
    ex_mem_hold   = 1'b0;
    mem_wb_bubble = 1'b0;
    if (rst) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      if_id_flush   = 1'b1;
      id_ex_bubble  = 1'b1;
      mem_wb_bubble = 1'b1;
    end else begin
      case (r_state)
        HZ_RUN, HZ_DONE: begin
          if ((r_state == HZ_RUN) && ex_mem_memaccess) begin
            dmem_req      = 1'b1;
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            ex_mem_hold   = 1'b1;
            mem_wb_bubble = 1'b1;
          end else if (ex_branch_taken) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
          end else if (w_load_use) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
          end
        end
        HZ_MWAIT: begin
          dmem_req      = 1'b1;
          pc_write      = 1'b0;
          if_id_write   = 1'b0;
          ex_mem_hold   = 1'b1;
          mem_wb_bubble = 1'b1;
        end
        default: ;
      endcase
    end
  end

  hazard_ctrl_wdog #(
    .MAX_WAIT (MAX_WAIT),
    .CNT_W    (CNT_W)
  ) u_wdog (
    .clk      (clk),
    .rst      (rst),
    .i_active (w_in_mwait),
    .i_ack    (dmem_ack),
    .o_wd_err (wd_err)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: per-scenario stimulus with expected
// output vectors queued at drive time and compared mid-cycle.
`timescale 1ns/1ps
module tb_hazard_ctrl;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       mr;
    logic [4:0] rd;
    logic       br;
    logic       ma;
    logic       ack;
  } stim_t;

  // Output vector order: {req, pc_w, ifid_w, flush, idex_bub, exmem_hold, memwb_bub, wd_err}
  localparam logic [7:0] E_CLEAN  = 8'b0110_0000;
  localparam logic [7:0] E_STALL  = 8'b0000_1000;
  localparam logic [7:0] E_BRANCH = 8'b0111_1000;
  localparam logic [7:0] E_FREEZE = 8'b1000_0110;
  localparam logic [7:0] E_RESET  = 8'b0001_1010;
  localparam logic [7:0] E_WD     = 8'b0000_0001;

  logic       clk;
  logic       rst;
  logic [4:0] if_id_rs1;
  logic [4:0] if_id_rs2;
  logic       id_ex_memread;
  logic [4:0] id_ex_rd;
  logic       ex_branch_taken;
  logic       ex_mem_memaccess;
  logic       dmem_ack;
  logic       dmem_req;
  logic       pc_write;
  logic       if_id_write;
  logic       if_id_flush;
  logic       id_ex_bubble;
  logic       ex_mem_hold;
  logic       mem_wb_bubble;
  logic       wd_err;
  logic [7:0] w_obs;

  logic [7:0] exp_q[$];
  int         n_vec;
  int         n_err;

  hazard_ctrl #(
    .MAX_WAIT (15),
    .CNT_W    (4)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .if_id_rs1        (if_id_rs1),
    .if_id_rs2        (if_id_rs2),
    .id_ex_memread    (id_ex_memread),
    .id_ex_rd         (id_ex_rd),
    .ex_branch_taken  (ex_branch_taken),
    .ex_mem_memaccess (ex_mem_memaccess),
    .dmem_ack         (dmem_ack),
    .dmem_req         (dmem_req),
    .pc_write         (pc_write),
    .if_id_write      (if_id_write),
    .if_id_flush      (if_id_flush),
    .id_ex_bubble     (id_ex_bubble),
    .ex_mem_hold      (ex_mem_hold),
    .mem_wb_bubble    (mem_wb_bubble),
    .wd_err           (wd_err)
  );

  assign w_obs = {dmem_req, pc_write, if_id_write, if_id_flush,
                  id_ex_bubble, ex_mem_hold, mem_wb_bubble, wd_err};

  always #5 clk = ~clk;

  function automatic stim_t mk(input int r, input int rs1, input int rs2, input int mr,
                               input int rd, input int br, input int ma, input int ack);
    stim_t s;
    s.rst = 1'(r);   s.rs1 = 5'(rs1); s.rs2 = 5'(rs2); s.mr  = 1'(mr);
    s.rd  = 5'(rd);  s.br  = 1'(br);  s.ma  = 1'(ma);  s.ack = 1'(ack);
    return s;
  endfunction

  // Apply one cycle of inputs and queue the outputs expected for that cycle.
  task automatic drive(input stim_t s, input logic [7:0] e);
    rst              = s.rst;
    if_id_rs1        = s.rs1;
    if_id_rs2        = s.rs2;
    id_ex_memread    = s.mr;
    id_ex_rd         = s.rd;
    ex_branch_taken  = s.br;
    ex_mem_memaccess = s.ma;
    dmem_ack         = s.ack;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    stim_t s[$]; logic [7:0] e[$]; logic [7:0] want;
    s.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0)); e.push_back(E_RESET);
    s.push_back(mk(1, 5, 0, 1, 5, 1, 0, 1)); e.push_back(E_RESET);
    s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(E_CLEAN);
    foreach (s[i]) begin
      drive(s[i], e[i]);
      #2;
      want = exp_q.pop_front();
      n_vec++;
      if (w_obs !== want) begin
        n_err++;
        $display("FAIL reset[%0d]: got %b expected %b", i, w_obs, want);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_load_use();
    stim_t s[$]; logic [7:0] e[$]; logic [7:0] want;
    s.push_back(mk(0, 1, 5, 1, 5, 0, 0, 0)); e.push_back(E_STALL);
    s.push_back(mk(0, 1, 5, 0, 0, 0, 0, 0)); e.push_back(E_CLEAN);
    s.push_back(mk(0, 5, 2, 1, 5, 0, 0, 0)); e.push_back(E_STALL);
    s.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0)); e.push_back(E_CLEAN);
    s.push_back(mk(0, 5, 5, 0, 5, 0, 0, 0)); e.push_back(E_CLEAN);
    s.push_back(mk(0, 5, 6, 1, 7, 0, 0, 0)); e.push_back(E_CLEAN);
    foreach (s[i]) begin
      drive(s[i], e[i]);
      #2;
      want = exp_q.pop_front();
      n_vec++;
      if (w_obs !== want) begin
        n_err++;
        $display("FAIL load_use[%0d]: got %b expected %b", i, w_obs, want);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_branch();
    stim_t s[$]; logic [7:0] e[$]; logic [7:0] want;
    s.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0)); e.push_back(E_BRANCH);
    s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(E_CLEAN);
    s.push_back(mk(0, 9, 3, 1, 9, 1, 0, 0)); e.push_back(E_BRANCH);
    s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(E_CLEAN);
    foreach (s[i]) begin
      drive(s[i], e[i]);
      #2;
      want = exp_q.pop_front();
      n_vec++;
      if (w_obs !== want) begin
        n_err++;
        $display("FAIL branch[%0d]: got %b expected %b", i, w_obs, want);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_mem_access();
    stim_t s[$]; logic [7:0] e[$]; logic [7:0] want;
    s.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0)); e.push_back(E_FREEZE);
    s.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0)); e.push_back(E_FREEZE);
    s.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1)); e.push_back(E_FREEZE);
    s.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0)); e.push_back(E_CLEAN);
    s.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0)); e.push_back(E_FREEZE);
    s.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1)); e.push_back(E_FREEZE);
    s.push_back(mk(0, 3, 0, 1, 3, 0, 1, 0)); e.push_back(E_STALL);
    s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(E_CLEAN);
    foreach (s[i]) begin
      drive(s[i], e[i]);
      #2;
      want = exp_q.pop_front();
      n_vec++;
      if (w_obs !== want) begin
        n_err++;
        $display("FAIL mem_access[%0d]: got %b expected %b", i, w_obs, want);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_branch_in_mwait();
    stim_t s[$]; logic [7:0] e[$]; logic [7:0] want;
    s.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0)); e.push_back(E_FREEZE);
    s.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0)); e.push_back(E_FREEZE);
    s.push_back(mk(0, 0, 0, 0, 0, 1, 1, 1)); e.push_back(E_FREEZE);
    s.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0)); e.push_back(E_BRANCH);
    s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(E_CLEAN);
    foreach (s[i]) begin
      drive(s[i], e[i]);
      #2;
      want = exp_q.pop_front();
      n_vec++;
      if (w_obs !== want) begin
        n_err++;
        $display("FAIL branch_in_mwait[%0d]: got %b expected %b", i, w_obs, want);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_spurious_ack();
    stim_t s[$]; logic [7:0] e[$]; logic [7:0] want;
    s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1)); e.push_back(E_CLEAN);
    s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1)); e.push_back(E_CLEAN);
    s.push_back(mk(0, 4, 0, 1, 4, 0, 0, 1)); e.push_back(E_STALL);
    s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(E_CLEAN);
    foreach (s[i]) begin
      drive(s[i], e[i]);
      #2;
      want = exp_q.pop_front();
      n_vec++;
      if (w_obs !== want) begin
        n_err++;
        $display("FAIL spurious_ack[%0d]: got %b expected %b", i, w_obs, want);
      end
      @(negedge clk);
    end
  endtask

  // Request cycle, then 15 MWAIT cycles with flag low; the flag is set at the
  // edge closing the 15th wait cycle and survives until reset.
  task automatic test_watchdog();
    stim_t s[$]; logic [7:0] e[$]; logic [7:0] want;
    s.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0)); e.push_back(E_FREEZE);
    for (int k = 1; k <= 15; k++) begin
      s.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0)); e.push_back(E_FREEZE);
    end
    for (int k = 16; k <= 18; k++) begin
      s.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0)); e.push_back(E_FREEZE | E_WD);
    end
    s.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1)); e.push_back(E_FREEZE | E_WD);
    s.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0)); e.push_back(E_CLEAN | E_WD);
    s.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0)); e.push_back(E_FREEZE | E_WD);
    s.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0)); e.push_back(E_RESET | E_WD);
    s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(E_CLEAN);
    s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(E_CLEAN);
    foreach (s[i]) begin
      drive(s[i], e[i]);
      #2;
      want = exp_q.pop_front();
      n_vec++;
      if (w_obs !== want) begin
        n_err++;
        $display("FAIL watchdog[%0d]: got %b expected %b", i, w_obs, want);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    clk              = 1'b0;
    rst              = 1'b1;
    if_id_rs1        = '0;
    if_id_rs2        = '0;
    id_ex_memread    = 1'b0;
    id_ex_rd         = '0;
    ex_branch_taken  = 1'b0;
    ex_mem_memaccess = 1'b0;
    dmem_ack         = 1'b0;
    n_vec            = 0;
    n_err            = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    test_reset();
    test_load_use();
    test_branch();
    test_mem_access();
    test_branch_in_mwait();
    test_spurious_ack();
    test_watchdog();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall controller for the 5-stage CPU. The forwarding unit resolves operand hazards by consuming results from EX/MEM and MEM/WB; this block covers the cases it cannot resolve. It stalls on load-use, flushes on taken branches, and freezes the pipeline while the data memory completes a multi-cycle access over a req/ack handshake. It drives the write-enables and flush controls of PC, IF/ID, ID/EX, EX/MEM and MEM/WB.

## Interface
- `MAX_WAIT`, default 15: watchdog limit, in cycles, on an outstanding data-memory access.
- `CNT_W`, default 4: width of the wait counter; must satisfy `2**CNT_W > MAX_WAIT`.

Clock and reset:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.

Hazard inputs:
- `if_id_rs1`  in  5  rs1 field of the instruction in ID.
- `if_id_rs2`  in  5  rs2 field of the instruction in ID.
- `id_ex_memread`  in  1  the instruction in EX is a load.
- `id_ex_rd`  in  5  destination register of the instruction in EX.
- `ex_branch_taken`  in  1  the branch or jump in EX resolved taken.
- `ex_mem_memaccess`  in  1  the instruction in MEM performs a load or store.
- `dmem_ack`  in  1  the data memory has completed the access.

Control outputs:
- `dmem_req`  out  1  access request to the data memory.
- `pc_write`  out  1  PC register enable.
- `if_id_write`  out  1  IF/ID register enable.
- `if_id_flush`  out  1  IF/ID loads a NOP.
- `id_ex_bubble`  out  1  ID/EX loads zeroed controls.
- `ex_mem_hold`  out  1  EX/MEM keeps its contents.
- `mem_wb_bubble`  out  1  MEM/WB loads zeroed controls.
- `wd_err`  out  1  sticky watchdog error flag.

## Operation
FSM states are RUN, MWAIT and DONE. The state is registered; all outputs are combinational from the state, the inputs and the counter, except `wd_err`, which is registered.

RUN:
- If `ex_mem_memaccess=1`: go to MWAIT. In this cycle `dmem_req=1` and the whole pipeline freezes (see "Freeze" below).
- Otherwise, if `ex_branch_taken=1`: `if_id_flush=1` and `id_ex_bubble=1`, with `pc_write=1` so the branch target loads.
- Otherwise, if there is a load-use hazard: `pc_write=0`, `if_id_write=0`, `id_ex_bubble=1`.
  - Load-use hazard means `id_ex_memread & id_ex_rd!=0 & (id_ex_rd==if_id_rs1 | id_ex_rd==if_id_rs2)`.
  - This inserts exactly one bubble. On the next cycle the load has moved to MEM, so the condition no longer holds.
- Otherwise: all enables are 1 and all flushes/bubbles are 0.

Freeze:
- `pc_write=0`, `if_id_write=0`, `ex_mem_hold=1`, `mem_wb_bubble=1`.
- `id_ex_bubble=0`: ID/EX is held, not bubbled. ID/EX hold is driven by `ex_mem_hold`.

MWAIT:
- `dmem_req=1`, freeze asserted, counter increments every cycle.
- On `dmem_ack=1`: go to DONE.
- If the counter reaches `MAX_WAIT` without `dmem_ack`: `wd_err` is set; stay in MWAIT.

DONE:
- Exactly one cycle with `dmem_req=0`.
- The MEM/WB bubble is released so the access result latches, and the pipeline advances: `ex_mem_hold=0`, `mem_wb_bubble=0`.
- Branch and load-use rules are evaluated as in RUN.
- Returns to RUN, even if the next instruction also accesses memory. The newly arrived instruction is detected in RUN on the following cycle.

Boundary conditions:
- Branch taken while in MWAIT: deferred. EX is frozen, so `ex_branch_taken` stays asserted and is acted on in DONE.
- Branch taken together with load-use: the branch wins. The flush discards the dependent instruction, so no stall occurs.
- Load-use with rd=x0: no stall.
- `dmem_ack` while `dmem_req=0`: ignored.
- `dmem_ack` in the same cycle as entry into MWAIT: not possible, because the memory sees `req` first.

## Timing
- Reset state is RUN with counter 0 and `wd_err=0`.
  - While `rst=1`, all outputs are forced to: `pc_write=0`, `if_id_write=0`, `if_id_flush=1`, `id_ex_bubble=1`, `mem_wb_bubble=1`, `ex_mem_hold=0`, `dmem_req=0`.
- `rst` asserted in MWAIT: abandons the access. `dmem_req` drops in the same cycle, and the next state is RUN.
- Memory access cost: N wait cycles plus one DONE cycle, where N is the number of cycles from `req` to `ack`, with N≥1.
- Load-use costs 1 cycle. A taken branch costs 2 squashed instructions.
- The counter saturates at `MAX_WAIT` and clears on leaving MWAIT.
- `wd_err` is cleared only by `rst`.

## Structure
- The shared package `cpu_pkg` holds:
  - the state encoding (`HZ_RUN=2'd0`, `HZ_MWAIT=2'd1`, `HZ_DONE=2'd2`);
  - the `REG_ZERO=5'd0` constant;
  - the `MAX_WAIT` default.
- One sub-module, `hazard_ctrl_wdog`, implements the wait counter, the saturation compare and the sticky `wd_err`.
- Load-use detection stays inline and combinational.

## Test plan
1. Load-use: `lw x5` in EX (`id_ex_memread=1`, `id_ex_rd=5`) with `if_id_rs2=5` → one cycle of `pc_write=0`, `if_id_write=0`, `id_ex_bubble=1`; the next cycle is clean. The same stimulus with `id_ex_rd=0` → no stall.
2. Taken branch: `ex_branch_taken=1` in RUN → `if_id_flush=1`, `id_ex_bubble=1`, `pc_write=1` for 1 cycle. Combined with a simultaneous load-use → identical outputs, with `if_id_write` still 1.
3. Memory access with ack after 3 cycles → `dmem_req` high for 3 cycles, freeze for 3 cycles, one DONE cycle with `ex_mem_hold=0`, then RUN.
4. Branch taken held through a 2-cycle MWAIT → no flush during MWAIT; flush asserted in the DONE cycle.
5. No ack with `MAX_WAIT=15` → `wd_err` rises on cycle 15 of MWAIT and stays high; a `rst` pulse clears it and drops `dmem_req` in the same cycle.
6. Spurious `dmem_ack=1` while in RUN with no access pending → no state change and all outputs unchanged.
